// File: rtl/constants.sv
// Design-wide constants shared by the register-file blocks.
package constants;
  localparam int WORD_LENGTH = 16;
endpackage

// File: rtl/reg_write_arb.sv
// Round-robin write arbiter: four requesters share one bus into eight enabled registers.
// All outputs are registered; a one-cycle last-grant mask stops a requester being granted twice in a row.
module reg_write_arb #(
  parameter int n = constants::WORD_LENGTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic [3:0]   req,
  input  logic [2:0]   addr0,
  input  logic [2:0]   addr1,
  input  logic [2:0]   addr2,
  input  logic [2:0]   addr3,
  input  logic [n-1:0] data0,
  input  logic [n-1:0] data1,
  input  logic [n-1:0] data2,
  input  logic [n-1:0] data3,
  output logic [3:0]   gnt,
  output logic [7:0]   wr_en,
  output logic [n-1:0] wr_data,
  output logic         busy
);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t         state;
  logic [1:0]     ptr;
  logic [3:0]     eligible;
  logic           found;
  logic [1:0]     sel;
  logic [1:0]     idx;
  logic [2:0]     sel_addr;
  logic [n-1:0]   sel_data;

  // Requester just granted is masked so it can drop req without a duplicate grant.
  always_comb begin
    eligible = stall ? 4'b0000 : (req & ~gnt);
    found    = 1'b0;
    sel      = 2'd0;
    idx      = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && eligible[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_comb begin
    sel_addr = addr0;
    sel_data = data0;
    case (sel)
      2'd0: begin sel_addr = addr0; sel_data = data0; end
      2'd1: begin sel_addr = addr1; sel_data = data1; end
      2'd2: begin sel_addr = addr2; sel_data = data2; end
      default: begin sel_addr = addr3; sel_data = data3; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= 2'd0;
      gnt     <= 4'b0000;
      wr_en   <= 8'h00;
      wr_data <= '0;
      busy    <= 1'b0;
    end else if (found) begin
      state   <= WRITE;
      ptr     <= sel + 2'd1;
      gnt     <= 4'b0001 << sel;
      wr_en   <= 8'h01 << sel_addr;
      wr_data <= sel_data;
      busy    <= 1'b1;
    end else begin
      // wr_data deliberately holds its last value while idle.
      state   <= IDLE;
      gnt     <= 4'b0000;
      wr_en   <= 8'h00;
      busy    <= 1'b0;
    end
  end

  logic unused_state;
  assign unused_state = (state == WRITE);

endmodule
